// File: rtl/mtimer_pkg.sv
// Shared constants and types for the machine timer block.
// Address map, CTRL layout and the byte-lane merge helper.
package mtimer_pkg;

   localparam logic [7:0] MTIME_OFF     = 8'h00;
   localparam logic [7:0] CTRL_OFF      = 8'h08;
   localparam logic [7:0] MSIP_OFF      = 8'h10;
   localparam logic [7:0] MTIMECMP_BASE = 8'h40;

   localparam logic [4:0] MTIME_IDX = MTIME_OFF[7:3];
   localparam logic [4:0] CTRL_IDX  = CTRL_OFF[7:3];
   localparam logic [4:0] MSIP_IDX  = MSIP_OFF[7:3];
   localparam logic [4:0] CMP_IDX   = MTIMECMP_BASE[7:3];

   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_DIV_LSB = 16;

   typedef struct packed {
      logic [15:0] rsvd_hi;
      logic [31:0] div;
      logic [14:0] rsvd_lo;
      logic        en;
   } ctrl_t;

   localparam ctrl_t CTRL_RST = '{
      rsvd_hi: '0,
      div:     '0,
      rsvd_lo: '0,
      en:      1'b1
   };

   // Upper-half accesses shift data and strobes into lanes 7..4.
   function automatic logic [63:0] merge_bytes(
      input logic [63:0] old,
      input logic [63:0] wdata,
      input logic [7:0]  we,
      input logic        hi
   );
      logic [63:0] wd;
      logic [7:0]  be;
      logic [63:0] res;
      wd  = hi ? {wdata[31:0], 32'd0} : wdata;
      be  = hi ? {we[3:0], 4'd0} : we;
      res = old;
      for (int b = 0; b < 8; b++) begin
         if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Prescaler: counts to DIV while enabled and emits a one-cycle tick.
// A CTRL write restarts the count from zero.
module mtimer_prescaler #(
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  en_i,
   input  logic                  clr_i,
   input  logic [PRESCALE_W-1:0] div_i,
   output logic                  tick_o
);

   logic [PRESCALE_W-1:0] pcnt_q;
   logic [PRESCALE_W-1:0] pcnt_d;

   assign tick_o = en_i && (pcnt_q == div_i);

   always_comb begin
      pcnt_d = pcnt_q;
      if (clr_i) begin
         pcnt_d = '0;
      end else if (tick_o) begin
         pcnt_d = '0;
      end else if (en_i) begin
         pcnt_d = pcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) pcnt_q <= '0;
      else          pcnt_q <= pcnt_d;
   end

endmodule

// File: rtl/mtimer.sv
// Machine timer: mtime with prescaler, per-hart mtimecmp/msip,
// and a 64-bit byte-enabled register port with 1-cycle reads.
module mtimer
   import mtimer_pkg::*;
#(
   parameter int NUM_HARTS  = 1,
   parameter int PRESCALE_W = 16
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 en_i,
   input  logic [7:0]           addr_i,
   input  logic [7:0]           we_i,
   input  logic [63:0]          data_i,
   output logic [63:0]          data_o,
   output logic [NUM_HARTS-1:0] mti_o,
   output logic [NUM_HARTS-1:0] msi_o,
   output logic [63:0]          mtime_o
);

   localparam logic [63:0] DIV_ONES =
      64'((65'd1 << PRESCALE_W) - 65'd1);
   localparam logic [63:0] CTRL_MASK =
      (DIV_ONES << CTRL_DIV_LSB) | (64'd1 << CTRL_EN_BIT);
   localparam logic [63:0] MSIP_MASK =
      64'((65'd1 << NUM_HARTS) - 65'd1);

   logic        wr_en;
   logic        rd_en;
   logic        hi;
   logic [4:0]  widx;
   logic        sel_mtime;
   logic        sel_ctrl;
   logic        sel_msip;
   logic        tick;
   logic        unused_addr;

   logic [63:0] mtime_q, mtime_d;
   ctrl_t       ctrl_q, ctrl_d;
   logic [63:0] msip_q, msip_d;
   logic [63:0] rdata_q, rdata_d;
   logic [63:0] rd_word;

   logic [63:0]          cmp_val [NUM_HARTS];
   logic [NUM_HARTS-1:0] cmp_sel;

   assign hi          = addr_i[2];
   assign widx        = addr_i[7:3];
   assign unused_addr = ^addr_i[1:0];
   assign wr_en       = en_i && (we_i != 8'd0);
   assign rd_en       = en_i && (we_i == 8'd0);
   assign sel_mtime   = (widx == MTIME_IDX);
   assign sel_ctrl    = (widx == CTRL_IDX);
   assign sel_msip    = (widx == MSIP_IDX);

   mtimer_prescaler #(
      .PRESCALE_W (PRESCALE_W)
   ) u_prescaler (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (ctrl_q.en),
      .clr_i   (wr_en && sel_ctrl),
      .div_i   (ctrl_q.div[PRESCALE_W-1:0]),
      .tick_o  (tick)
   );

   // A write to mtime takes priority over a coincident tick.
   always_comb begin
      mtime_d = mtime_q;
      if (wr_en && sel_mtime) begin
         mtime_d = merge_bytes(mtime_q, data_i, we_i, hi);
      end else if (tick) begin
         mtime_d = mtime_q + 64'd1;
      end
   end

   always_comb begin
      ctrl_d = ctrl_q;
      msip_d = msip_q;
      if (wr_en && sel_ctrl) begin
         ctrl_d = ctrl_t'(
            merge_bytes(ctrl_q, data_i, we_i, hi) & CTRL_MASK);
      end
      if (wr_en && sel_msip) begin
         msip_d = merge_bytes(msip_q, data_i, we_i, hi) & MSIP_MASK;
      end
   end

   always_comb begin
      rd_word = '0;
      unique case (1'b1)
         sel_mtime: rd_word = mtime_q;
         sel_ctrl:  rd_word = ctrl_q;
         sel_msip:  rd_word = msip_q;
         default: begin
            for (int h = 0; h < NUM_HARTS; h++) begin
               if (cmp_sel[h]) rd_word = cmp_val[h];
            end
         end
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      if (rd_en) begin
         rdata_d = hi ? {32'd0, rd_word[63:32]} : rd_word;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mtime_q <= '0;
         ctrl_q  <= CTRL_RST;
         msip_q  <= '0;
         rdata_q <= '0;
      end else begin
         mtime_q <= mtime_d;
         ctrl_q  <= ctrl_d;
         msip_q  <= msip_d;
         rdata_q <= rdata_d;
      end
   end

   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
      logic        sel;
      logic [63:0] cmp_q, cmp_d;
      logic        mti_q, mti_d;

      assign sel        = (widx == CMP_IDX + 5'(h));
      assign cmp_sel[h] = sel;
      assign cmp_val[h] = cmp_q;
      assign mti_o[h]   = mti_q;

      always_comb begin
         cmp_d = cmp_q;
         mti_d = (mtime_q >= cmp_q);
         if (wr_en && sel) begin
            cmp_d = merge_bytes(cmp_q, data_i, we_i, hi);
         end
      end

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cmp_q <= '1;
            mti_q <= 1'b0;
         end else begin
            cmp_q <= cmp_d;
            mti_q <= mti_d;
         end
      end
   end

   assign data_o  = rdata_q;
   assign msi_o   = msip_q[NUM_HARTS-1:0];
   assign mtime_o = mtime_q;

endmodule

// File: tb/tb_mtimer.sv
// Bench for mtimer: directed scenarios plus random bus traffic,
// all checked against a cycle-level arithmetic model.
module tb_mtimer;

   localparam int NH = 2;

   logic          clk;
   logic          reset_n;
   logic          en_i;
   logic [7:0]    addr_i;
   logic [7:0]    we_i;
   logic [63:0]   data_i;
   logic [63:0]   data_o;
   logic [NH-1:0] mti_o;
   logic [NH-1:0] msi_o;
   logic [63:0]   mtime_o;

   int n_cmp = 0;
   int n_bad = 0;

   logic [63:0] m_mtime;
   int          m_pcnt;
   logic        m_en;
   int          m_div;
   logic [1:0]  m_msip;
   logic [63:0] m_cmp [NH];
   logic [63:0] m_data;
   logic [1:0]  m_mti;

   mtimer #(
      .NUM_HARTS  (NH),
      .PRESCALE_W (16)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .en_i    (en_i),
      .addr_i  (addr_i),
      .we_i    (we_i),
      .data_i  (data_i),
      .data_o  (data_o),
      .mti_o   (mti_o),
      .msi_o   (msi_o),
      .mtime_o (mtime_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [63:0] obs,
                        input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_mtime = '0;
      m_pcnt  = 0;
      m_en    = 1'b1;
      m_div   = 0;
      m_msip  = '0;
      m_data  = '0;
      m_mti   = '0;
      for (int h = 0; h < NH; h++) m_cmp[h] = '1;
   endtask

   function automatic logic [63:0] ctrl_word();
      return (64'(m_div) << 16) | 64'(m_en);
   endfunction

   function automatic logic [63:0] model_read(input logic [7:0] a);
      logic [63:0] word;
      int idx;
      idx = int'(a[7:3]);
      word = '0;
      if (idx == 0) word = m_mtime;
      else if (idx == 1) word = ctrl_word();
      else if (idx == 2) word = 64'(m_msip);
      else if (idx >= 8 && idx < 8 + NH) word = m_cmp[idx-8];
      if (a[2]) word = word >> 32;
      return word;
   endfunction

   function automatic logic [63:0] lane_write(input logic [63:0] old,
                                              input logic [7:0] a,
                                              input logic [7:0] w,
                                              input logic [63:0] d);
      logic [63:0] r;
      r = old;
      if (a[2]) begin
         for (int b = 0; b < 4; b++)
            if (w[b]) r[32+8*b +: 8] = d[8*b +: 8];
      end else begin
         for (int b = 0; b < 8; b++)
            if (w[b]) r[8*b +: 8] = d[8*b +: 8];
      end
      return r;
   endfunction

   task automatic model_step(input logic e, input logic [7:0] a,
                             input logic [7:0] w, input logic [63:0] d);
      logic        tick;
      logic [63:0] old_mtime;
      logic [63:0] nxt;
      int          idx;
      idx = int'(a[7:3]);
      old_mtime = m_mtime;
      if (e && w == 8'd0) m_data = model_read(a);
      for (int h = 0; h < NH; h++) m_mti[h] = (m_mtime >= m_cmp[h]);
      tick = m_en && (m_pcnt == m_div);
      if (tick) m_pcnt = 0;
      else if (m_en) m_pcnt = (m_pcnt + 1) % 65536;
      if (tick) m_mtime = m_mtime + 64'd1;
      if (e && w != 8'd0) begin
         if (idx == 0) begin
            m_mtime = lane_write(old_mtime, a, w, d);
         end else if (idx == 1) begin
            nxt = lane_write(ctrl_word(), a, w, d);
            m_en = nxt[0];
            m_div = int'(nxt[31:16]);
            m_pcnt = 0;
         end else if (idx == 2) begin
            nxt = lane_write(64'(m_msip), a, w, d);
            m_msip = nxt[1:0];
         end else if (idx >= 8 && idx < 8 + NH) begin
            m_cmp[idx-8] = lane_write(m_cmp[idx-8], a, w, d);
         end
      end
   endtask

   task automatic step(input logic e, input logic [7:0] a,
                       input logic [7:0] w, input logic [63:0] d);
      en_i = e;
      addr_i = a;
      we_i = w;
      data_i = d;
      @(posedge clk);
      model_step(e, a, w, d);
      @(negedge clk);
      check("mtime", mtime_o, m_mtime);
      check("data_o", data_o, m_data);
      check("mti", 64'(mti_o), 64'(m_mti));
      check("msi", 64'(msi_o), 64'(m_msip));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 8'h00, 64'd0);
   endtask

   task automatic mid_reset();
      en_i = 1'b1;
      addr_i = 8'h00;
      we_i = 8'hFF;
      data_i = 64'hDEAD_BEEF_0123_4567;
      #2 reset_n = 1'b0;
      model_reset();
      #1;
      check("arst_mtime", mtime_o, 64'd0);
      check("arst_data", data_o, 64'd0);
      check("arst_msi", 64'(msi_o), 64'd0);
      check("arst_mti", 64'(mti_o), 64'd0);
      @(posedge clk);
      @(negedge clk);
      en_i = 1'b0;
      we_i = 8'h00;
      reset_n = 1'b1;
      step(1'b1, 8'h40, 8'h00, 64'd0);
      check("arst_cmp0", data_o, 64'hFFFF_FFFF_FFFF_FFFF);
      step(1'b1, 8'h08, 8'h00, 64'd0);
      check("arst_ctrl", data_o, 64'd1);
   endtask

   task automatic random_op();
      int          k;
      int          h;
      logic [7:0]  a;
      logic [7:0]  w;
      logic [63:0] d;
      k = $urandom_range(0, 9);
      h = $urandom_range(0, NH - 1);
      a = 8'($urandom);
      w = 8'($urandom_range(1, 255));
      d = {$urandom, $urandom};
      case (k)
         0, 1: step(1'b0, a, w, d);
         2, 3: step(1'b1, a, 8'h00, d);
         4: begin
            d[31:16] = 16'($urandom_range(0, 3));
            d[0] = ($urandom_range(0, 4) != 0);
            step(1'b1, {5'h01, a[2:0]}, w, d);
         end
         5: begin
            if ($urandom_range(0, 1) == 1)
               d = ~64'($urandom_range(0, 40));
            step(1'b1, {5'h00, a[2:0]}, w, d);
         end
         6, 7: begin
            if (!a[2]) d = m_mtime + 64'($urandom_range(0, 30));
            step(1'b1, {5'(8 + h), a[2:0]}, w, d);
         end
         8: step(1'b1, {5'h02, a[2:0]}, w, d);
         default: step(1'b1, a, w, d);
      endcase
   endtask

   initial begin
      bit hit;
      reset_n = 1'b0;
      en_i = 1'b0;
      addr_i = 8'h00;
      we_i = 8'h00;
      data_i = 64'd0;
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_mtime", mtime_o, 64'd0);
      check("rst_data", data_o, 64'd0);
      check("rst_mti", 64'(mti_o), 64'd0);
      check("rst_msi", 64'(msi_o), 64'd0);
      reset_n = 1'b1;

      for (int i = 0; i < 5; i++) begin
         idle(1);
         check("free_run", mtime_o, 64'(i + 1));
      end

      step(1'b1, 8'h08, 8'hFF, 64'h0003_0001);
      step(1'b1, 8'h00, 8'hFF, 64'd0);
      idle(8);
      check("div3_rate", mtime_o, 64'd2);
      step(1'b1, 8'h00, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
      hit = 1'b0;
      for (int i = 0; i < 8 && !hit; i++) begin
         idle(1);
         hit = (mtime_o != 64'hFFFF_FFFF_FFFF_FFFF);
      end
      check("wrap_seen", 64'(hit), 64'd1);
      check("wrap_zero", mtime_o, 64'd0);

      step(1'b1, 8'h08, 8'hFF, 64'h0000_0001);
      step(1'b1, 8'h48, 8'hFF, 64'h10);
      step(1'b1, 8'h00, 8'hFF, 64'h0E);
      hit = 1'b0;
      for (int i = 0; i < 10 && !hit; i++) begin
         idle(1);
         hit = mti_o[1];
      end
      check("mti1_seen", 64'(hit), 64'd1);
      check("mti1_time", mtime_o, 64'h11);
      check("mti0_low", 64'(mti_o[0]), 64'd0);

      step(1'b1, 8'h44, 8'h0F, 64'h0000_0001);
      step(1'b1, 8'h40, 8'h00, 64'd0);
      check("cmp0_lo", data_o, 64'h0000_0001_FFFF_FFFF);
      step(1'b1, 8'h44, 8'h00, 64'd0);
      check("cmp0_hi", data_o, 64'h0000_0000_0000_0001);

      step(1'b1, 8'h10, 8'h01, 64'h2);
      step(1'b1, 8'h08, 8'h01, 64'h0);
      step(1'b1, 8'h00, 8'hFF, 64'h55);
      idle(5);
      check("msi_val", 64'(msi_o), 64'd2);
      check("frozen", mtime_o, 64'h55);
      step(1'b1, 8'h10, 8'h00, 64'd0);
      check("msip_rd", data_o, 64'd2);
      step(1'b1, 8'h30, 8'h00, 64'd0);
      check("unmapped_rd", data_o, 64'd0);
      step(1'b1, 8'h08, 8'hFF, 64'h0000_0001);

      for (int i = 0; i < 1500; i++) random_op();
      mid_reset();
      for (int i = 0; i < 300; i++) random_op();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
